// File: rtl/store_write_queue.sv
// ============================================================================
// store_write_queue: store AdES check, sw/sh/sb lane formatting, DEPTH-entry write FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

module store_write_queue #(
   parameter int          DEPTH    = 4,
   parameter int          CNT_W    = 3,
   parameter logic [31:0] DM_BASE  = 32'h0000_0000,
   parameter logic [31:0] DM_END   = 32'h0000_2fff,
   parameter logic [31:0] TC1_BASE = 32'h0000_7f00,
   parameter logic [31:0] TC2_BASE = 32'h0000_7f10,
   parameter logic [31:0] IG_BASE  = 32'h0000_7f20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             st_valid,
   input  logic [31:0]      st_addr,
   input  logic [31:0]      st_data,
   input  logic [2:0]       st_op,
   input  logic             st_dmov,
   output logic             st_ready,
   output logic             exc_ades,
   input  logic             ld_valid,
   input  logic [31:0]      ld_addr,
   output logic             ld_conflict,
   output logic             bus_valid,
   output logic [31:0]      bus_addr,
   output logic [3:0]       bus_byteen,
   output logic [31:0]      bus_wdata,
   input  logic             bus_ready,
   output logic [CNT_W-1:0] count,
   output logic             idle
);

   localparam int          PTR_W      = CNT_W - 1;
   localparam logic [2:0]  OP_WORD    = 3'd0;
   localparam logic [2:0]  OP_HALF    = 3'd1;
   localparam logic [2:0]  OP_BYTE    = 3'd2;
   localparam logic [31:0] TC_SPAN    = 32'd11;
   localparam logic [31:0] TC_CNT_OFF = 32'd8;
   localparam logic [31:0] IG_SPAN    = 32'd3;
   localparam logic [31:0] DM_SPAN    = DM_END - DM_BASE;

   // ------------------------------------------------------------------
   // Address checking
   // ------------------------------------------------------------------
   logic [31:0] dm_off, tc1_off, tc2_off, ig_off;
   logic        in_dm, in_tc1, in_tc2, in_ig;
   logic        is_half, is_byte, is_word;
   logic        misalign, out_of_range, timer_violation;

   // Offsets wrap below the base, so one unsigned compare covers both window ends.
   assign dm_off  = st_addr - DM_BASE;
   assign tc1_off = st_addr - TC1_BASE;
   assign tc2_off = st_addr - TC2_BASE;
   assign ig_off  = st_addr - IG_BASE;

   assign in_dm  = (dm_off  <= DM_SPAN);
   assign in_tc1 = (tc1_off <= TC_SPAN);
   assign in_tc2 = (tc2_off <= TC_SPAN);
   assign in_ig  = (ig_off  <= IG_SPAN);

   assign is_half = (st_op == OP_HALF);
   assign is_byte = (st_op == OP_BYTE);
   assign is_word = !(is_half || is_byte);

   assign misalign        = (is_word && (st_addr[1:0] != 2'b00)) ||
                            (is_half && st_addr[0]);
   assign out_of_range    = !(in_dm || in_tc1 || in_tc2 || in_ig);
   assign timer_violation = (in_tc1 && ((tc1_off >= TC_CNT_OFF) || !is_word)) ||
                            (in_tc2 && ((tc2_off >= TC_CNT_OFF) || !is_word));

   assign exc_ades = st_valid && (misalign || out_of_range || timer_violation || st_dmov);

   // ------------------------------------------------------------------
   // Store formatting
   // ------------------------------------------------------------------
   logic [3:0]  fmt_be;
   logic [31:0] fmt_rep;
   logic [31:0] fmt_mask;
   logic [31:0] fmt_data;

   always_comb begin
      fmt_be  = 4'b1111;
      fmt_rep = st_data;
      if (is_byte) begin
         fmt_be  = 4'b0001 << st_addr[1:0];
         fmt_rep = {4{st_data[7:0]}};
      end else if (is_half) begin
         fmt_be  = st_addr[1] ? 4'b1100 : 4'b0011;
         fmt_rep = {2{st_data[15:0]}};
      end
   end

   // Replicated data is cut down to the enabled lanes; all other lanes read zero.
   assign fmt_mask = {{8{fmt_be[3]}}, {8{fmt_be[2]}}, {8{fmt_be[1]}}, {8{fmt_be[0]}}};
   assign fmt_data = fmt_rep & fmt_mask;

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   logic [29:0]      q_addr [DEPTH];
   logic [3:0]       q_be   [DEPTH];
   logic [31:0]      q_data [DEPTH];
   logic [DEPTH-1:0] ent_valid;
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic             full;
   logic             push, pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign st_ready = !full;
   assign push     = st_valid && st_ready && !exc_ades;
   assign pop      = bus_valid && bus_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         ent_valid <= '0;
      end else begin
         if (push) begin
            wr_ptr            <= wr_ptr + PTR_W'(1);
            ent_valid[wr_ptr] <= 1'b1;
         end
         if (pop) begin
            rd_ptr            <= rd_ptr + PTR_W'(1);
            ent_valid[rd_ptr] <= 1'b0;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload needs no reset: it is only visible through ent_valid / count.
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wr_ptr] <= st_addr[31:2];
         q_be[wr_ptr]   <= fmt_be;
         q_data[wr_ptr] <= fmt_data;
      end
   end

   // ------------------------------------------------------------------
   // Bus side and load hazard
   // ------------------------------------------------------------------
   assign bus_valid  = (count != '0);
   assign idle       = (count == '0);
   assign bus_addr   = bus_valid ? {q_addr[rd_ptr], 2'b00} : 32'd0;
   assign bus_byteen = bus_valid ? q_be[rd_ptr]             : 4'd0;
   assign bus_wdata  = bus_valid ? q_data[rd_ptr]           : 32'd0;

   logic [DEPTH-1:0] hit;
   logic [1:0]       unused_ld_lsb;

   for (genvar i = 0; i < DEPTH; i++) begin : g_hit
      assign hit[i] = ent_valid[i] && (q_addr[i] == ld_addr[31:2]);
   end

   assign ld_conflict   = ld_valid && (|hit);
   assign unused_ld_lsb = ld_addr[1:0];

endmodule

`default_nettype wire

// File: tb/tb_store_write_queue.sv
// ============================================================================
// tb_store_write_queue: directed stimulus, queue-based reference model, per-cycle compare
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_store_write_queue;

   localparam int         DEPTH   = 4;
   localparam int         CNT_W   = 3;
   localparam logic [2:0] OP_WORD = 3'd0;
   localparam logic [2:0] OP_HALF = 3'd1;
   localparam logic [2:0] OP_BYTE = 3'd2;

   logic             clk = 1'b0;
   logic             reset;
   logic             st_valid;
   logic [31:0]      st_addr;
   logic [31:0]      st_data;
   logic [2:0]       st_op;
   logic             st_dmov;
   logic             st_ready;
   logic             exc_ades;
   logic             ld_valid;
   logic [31:0]      ld_addr;
   logic             ld_conflict;
   logic             bus_valid;
   logic [31:0]      bus_addr;
   logic [3:0]       bus_byteen;
   logic [31:0]      bus_wdata;
   logic             bus_ready;
   logic [CNT_W-1:0] count;
   logic             idle;

   int checks   = 0;
   int failures = 0;

   store_write_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .st_valid   (st_valid),
      .st_addr    (st_addr),
      .st_data    (st_data),
      .st_op      (st_op),
      .st_dmov    (st_dmov),
      .st_ready   (st_ready),
      .exc_ades   (exc_ades),
      .ld_valid   (ld_valid),
      .ld_addr    (ld_addr),
      .ld_conflict(ld_conflict),
      .bus_valid  (bus_valid),
      .bus_addr   (bus_addr),
      .bus_byteen (bus_byteen),
      .bus_wdata  (bus_wdata),
      .bus_ready  (bus_ready),
      .count      (count),
      .idle       (idle)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   typedef struct packed {
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] d;
   } ent_t;

   ent_t q[$];
   bit   mvalid = 1'b0;

   function automatic bit model_ades(input logic [31:0] a, input logic [2:0] op, input logic dm);
      bit half, byt, word, mis, t1, t2, in_any, tv;
      half   = (op == OP_HALF);
      byt    = (op == OP_BYTE);
      word   = !half && !byt;
      mis    = (word && (a % 4 != 0)) || (half && (a % 2 != 0));
      t1     = (a >= 32'h7f00) && (a <= 32'h7f0b);
      t2     = (a >= 32'h7f10) && (a <= 32'h7f1b);
      in_any = (a <= 32'h2fff) || t1 || t2 || ((a >= 32'h7f20) && (a <= 32'h7f23));
      tv     = (t1 && (a >= 32'h7f08 || !word)) || (t2 && (a >= 32'h7f18 || !word));
      return mis || !in_any || tv || dm;
   endfunction

   function automatic ent_t model_fmt(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
      ent_t e;
      e.a = {a[31:2], 2'b00};
      if (op == OP_BYTE) begin
         e.be = 4'(1 << a[1:0]);
         e.d  = 32'(d[7:0]) << (8 * a[1:0]);
      end else if (op == OP_HALF) begin
         e.be = a[1] ? 4'b1100 : 4'b0011;
         e.d  = a[1] ? {d[15:0], 16'h0} : {16'h0, d[15:0]};
      end else begin
         e.be = 4'b1111;
         e.d  = d;
      end
      return e;
   endfunction

   always @(posedge clk) begin
      bit do_pop, do_push;
      if (reset) begin
         q.delete();
         mvalid = 1'b1;
      end else if (mvalid) begin
         do_pop  = (q.size() > 0) && bus_ready;
         do_push = st_valid && (q.size() < DEPTH) && !model_ades(st_addr, st_op, st_dmov);
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(model_fmt(st_addr, st_data, st_op));
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      bit   lc;
      ent_t h;
      if (mvalid) begin
         lc = 1'b0;
         foreach (q[k]) if (q[k].a[31:2] == ld_addr[31:2]) lc = 1'b1;
         h = (q.size() > 0) ? q[0] : '0;
         chk("m_st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
         chk("m_exc_ades", 32'(exc_ades), 32'(st_valid && model_ades(st_addr, st_op, st_dmov)));
         chk("m_bus_valid", 32'(bus_valid), 32'(q.size() > 0));
         chk("m_bus_addr", bus_addr, h.a);
         chk("m_bus_byteen", 32'(bus_byteen), 32'(h.be));
         chk("m_bus_wdata", bus_wdata, h.d);
         chk("m_count", 32'(count), 32'(q.size()));
         chk("m_idle", 32'(idle), 32'(q.size() == 0));
         chk("m_ld_conflict", 32'(ld_conflict), 32'(ld_valid && lc));
      end
   end

   // ------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic st(input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] op, input logic dm);
      st_valid = v;
      st_addr  = a;
      st_data  = d;
      st_op    = op;
      st_dmov  = dm;
   endtask

   initial begin
      reset = 1'b1; bus_ready = 1'b0; ld_valid = 1'b0; ld_addr = '0;
      st(1'b0, 32'h0, 32'h0, OP_WORD, 1'b0);
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_bus_valid", 32'(bus_valid), 32'd0);

      // sb to byte 3 lands in lane 3
      tick();
      bus_ready = 1'b1;
      st(1'b1, 32'h3, 32'h1122_3344, OP_BYTE, 1'b0);
      tick();
      st_valid = 1'b0;
      @(negedge clk);
      chk("sb_bus_valid", 32'(bus_valid), 32'd1);
      chk("sb_bus_addr", bus_addr, 32'h0);
      chk("sb_byteen", 32'(bus_byteen), 32'b1000);
      chk("sb_wdata", bus_wdata, 32'h4400_0000);
      tick();
      @(negedge clk);
      chk("sb_idle", 32'(idle), 32'd1);

      // timer window rules
      tick();
      bus_ready = 1'b0;
      st(1'b1, 32'h7f08, 32'hdead_beef, OP_WORD, 1'b0);
      @(negedge clk);
      chk("tc_cnt_ades", 32'(exc_ades), 32'd1);
      tick();
      st(1'b1, 32'h7f00, 32'h1234, OP_HALF, 1'b0);
      @(negedge clk);
      chk("tc_half_ades", 32'(exc_ades), 32'd1);
      chk("tc_count0", 32'(count), 32'd0);
      tick();
      st(1'b1, 32'h7f04, 32'h0000_00aa, OP_WORD, 1'b0);
      @(negedge clk);
      chk("tc_ok_ades", 32'(exc_ades), 32'd0);
      tick();
      st_valid = 1'b0;
      @(negedge clk);
      chk("tc_ok_count", 32'(count), 32'd1);
      bus_ready = 1'b1;
      tick(); tick();
      bus_ready = 1'b0;

      // fill to DEPTH, fifth store refused, then drain in order
      for (int i = 0; i < 5; i++) begin
         st(1'b1, 32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), OP_WORD, 1'b0);
         @(negedge clk);
         if (i == 4) chk("full_st_ready", 32'(st_ready), 32'd0);
         tick();
      end
      st_valid = 1'b0;
      @(negedge clk);
      chk("full_count", 32'(count), 32'd4);
      tick();
      bus_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("drain_addr", bus_addr, 32'h10 + 32'(4 * j));
         if (j == 0) chk("drain_ready_pop", 32'(st_ready), 32'd0);
         if (j == 1) chk("drain_ready_after", 32'(st_ready), 32'd1);
         tick();
      end
      @(negedge clk);
      chk("drain_idle", 32'(idle), 32'd1);

      // simultaneous push and pop keeps count steady
      tick();
      for (int i = 0; i < 3; i++) begin
         st(1'b1, 32'h40 + 32'(4 * i), 32'h5500_0000 + 32'(i), OP_WORD, 1'b0);
         tick();
         if (i > 0) begin
            @(negedge clk);
            chk("pp_count", 32'(count), 32'd1);
            #1;
         end
      end
      st_valid = 1'b0;
      tick(); tick();

      // load hazard against queued store word
      bus_ready = 1'b0;
      st(1'b1, 32'h100, 32'h0bad_f00d, OP_WORD, 1'b0);
      tick();
      st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h102;
      @(negedge clk);
      chk("ld_hit", 32'(ld_conflict), 32'd1);
      tick();
      ld_addr = 32'h104;
      @(negedge clk);
      chk("ld_miss", 32'(ld_conflict), 32'd0);
      tick();
      ld_addr = 32'h100; bus_ready = 1'b1;
      @(negedge clk);
      chk("ld_hit_popping", 32'(ld_conflict), 32'd1);
      tick();
      bus_ready = 1'b0;
      st(1'b1, 32'h200, 32'h1, OP_WORD, 1'b0); ld_addr = 32'h200;
      @(negedge clk);
      chk("ld_same_cycle_push", 32'(ld_conflict), 32'd0);
      tick();
      st_valid = 1'b0;
      @(negedge clk);
      chk("ld_after_push", 32'(ld_conflict), 32'd1);
      tick();
      ld_valid = 1'b0; bus_ready = 1'b1;
      tick();
      bus_ready = 1'b0;

      // halfword formatting, upper lane
      st(1'b1, 32'h202, 32'hAABB_CCDD, OP_HALF, 1'b0);
      tick();
      st(1'b1, 32'h7f23, 32'h0000_0077, OP_BYTE, 1'b0);
      @(negedge clk);
      chk("sh_byteen", 32'(bus_byteen), 32'b1100);
      chk("sh_wdata", bus_wdata, 32'hCCDD_0000);
      chk("ig_byte_ades", 32'(exc_ades), 32'd0);
      tick();

      // reset in the middle of a pending handshake
      st(1'b1, 32'h300, 32'h3, OP_WORD, 1'b0);
      tick();
      st_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      chk("prerst_count", 32'(count), 32'd3);
      chk("prerst_bus_valid", 32'(bus_valid), 32'd1);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_bus_valid", 32'(bus_valid), 32'd0);
      chk("midrst_idle", 32'(idle), 32'd1);
      chk("midrst_wdata", bus_wdata, 32'd0);

      // out-of-range, overflow, misalign, gap between windows
      tick();
      st(1'b1, 32'h3000, 32'h9, OP_WORD, 1'b0);
      @(negedge clk);
      chk("oor_ades", 32'(exc_ades), 32'd1);
      tick();
      st(1'b1, 32'h100, 32'h9, OP_WORD, 1'b1);
      @(negedge clk);
      chk("dmov_ades", 32'(exc_ades), 32'd1);
      tick();
      st(1'b1, 32'h101, 32'h9, OP_WORD, 1'b0);
      @(negedge clk);
      chk("misalign_ades", 32'(exc_ades), 32'd1);
      tick();
      st(1'b1, 32'h7f0c, 32'h9, OP_WORD, 1'b0);
      @(negedge clk);
      chk("gap_ades", 32'(exc_ades), 32'd1);
      tick();
      st(1'b1, 32'h7f14, 32'h9, OP_WORD, 1'b0);
      @(negedge clk);
      chk("tc2_ok_ades", 32'(exc_ades), 32'd0);
      tick();
      st_valid = 1'b0;
      @(negedge clk);
      chk("exc_count", 32'(count), 32'd1);
      bus_ready = 1'b1;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
